// File: rtl/id_hazard_ctrl_pkg.sv
// Shared pipeline control types for the 5-stage core: stage control bundles
// and the hazard controller state encoding.
package id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic [2:0] width;
    logic       mem_unsigned;
    logic       mem_write;
    logic       mem_read;
    logic       mem_en;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam int MEM_RD_BIT = 1;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface id_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       i_rdReg1;
  logic [4:0]       i_rdReg2;
  logic             i_idValid;
  logic [6:0]       i_exCtrlMEM;
  logic [4:0]       i_exWriteReg;
  logic             i_redirect;
  logic             i_dmemBusy;
  logic             i_cntClr;
  logic             o_pcWrite;
  logic             o_ifidWrite;
  logic             o_ifidFlush;
  logic             o_idexWrite;
  logic             o_idexBubble;
  logic             o_exmemWrite;
  logic             o_exmemFlush;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stallCnt;
  logic [CNT_W-1:0] o_flushCnt;
  logic             o_memTimeout;

  modport slave (
    input  i_rdReg1, i_rdReg2, i_idValid, i_exCtrlMEM, i_exWriteReg,
           i_redirect, i_dmemBusy, i_cntClr,
    output o_pcWrite, o_ifidWrite, o_ifidFlush, o_idexWrite, o_idexBubble,
           o_exmemWrite, o_exmemFlush, o_state, o_stallCnt, o_flushCnt, o_memTimeout
  );

  modport master (
    output i_rdReg1, i_rdReg2, i_idValid, i_exCtrlMEM, i_exWriteReg,
           i_redirect, i_dmemBusy, i_cntClr,
    input  o_pcWrite, o_ifidWrite, o_ifidFlush, o_idexWrite, o_idexBubble,
           o_exmemWrite, o_exmemFlush, o_state, o_stallCnt, o_flushCnt, o_memTimeout
  );
endinterface

// File: rtl/id_hazard_ctrl_hz_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                     cnt_d = '0;
    else if (i_inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard controller beside ID: load-use stalls, MEM-resolved redirects and
// data-memory freezes, plus debug stall/flush counters and a timeout flag.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input logic              i_clk,
  input logic              i_rst_n,
  id_hazard_ctrl_if.slave  hz
);

  localparam int RUN_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MEM_TIMEOUT);

  hazard_state_t    state_q, state_d;
  logic             lu;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic             exmem_write, exmem_flush, flush_inc;
  logic [RUN_W-1:0] busy_run_q, busy_run_d;
  logic             timeout_q, timeout_d;

  // In LDSTALL the load has moved to MEM and is forwarded, so the match is stale.
  assign lu = hz.i_idValid && hz.i_exCtrlMEM[MEM_RD_BIT] && (state_q != ST_LDSTALL)
              && src_match(hz.i_exWriteReg, hz.i_rdReg1, hz.i_rdReg2);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    flush_inc   = 1'b0;
    if (hz.i_dmemBusy) begin
      // Full freeze; a redirect in EX/MEM is held there and taken once memory frees up.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = ST_MEMWAIT;
    end else if (hz.i_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      flush_inc   = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_LDSTALL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    busy_run_d = '0;
    timeout_d  = timeout_q;
    if (hz.i_cntClr) begin
      timeout_d = 1'b0;
    end else if (hz.i_dmemBusy) begin
      busy_run_d = (busy_run_q == RUN_MAX) ? busy_run_q : busy_run_q + 1'b1;
      if (busy_run_d == RUN_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_run_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      busy_run_q <= busy_run_d;
      timeout_q  <= timeout_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (!pc_write),
    .i_clr   (hz.i_cntClr),
    .o_cnt   (hz.o_stallCnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flush_inc),
    .i_clr   (hz.i_cntClr),
    .o_cnt   (hz.o_flushCnt)
  );

  assign hz.o_pcWrite    = pc_write;
  assign hz.o_ifidWrite  = ifid_write;
  assign hz.o_ifidFlush  = ifid_flush;
  assign hz.o_idexWrite  = idex_write;
  assign hz.o_idexBubble = idex_bubble;
  assign hz.o_exmemWrite = exmem_write;
  assign hz.o_exmemFlush = exmem_flush;
  assign hz.o_state      = state_q;
  assign hz.o_memTimeout = timeout_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: vector table through a scoreboard,
// then timeout, counter saturation and async reset sequences.
module tb_id_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO   = 4;

  // Control bundle order: {pc, ifid_w, ifid_f, idex_w, idex_bub, exmem_w, exmem_f}
  localparam logic [6:0] C_RUN   = 7'b1101010;
  localparam logic [6:0] C_BUSY  = 7'b0000000;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_LU    = 7'b0001110;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       idv, memrd;
    logic [4:0] exwr;
    logic       redir, busy, clr;
    logic [6:0] ctrl;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic [6:0]       ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall, flush;
    logic             tmo;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  id_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .hz      (hif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t tbl[23];

  logic [CNT_W-1:0] m_stall, m_flush;
  int               m_run;
  logic             m_tmo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic idv, input logic memrd, input logic [4:0] exwr,
                              input logic redir, input logic busy, input logic clr,
                              input logic [6:0] ctrl, input logic [1:0] st);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.idv = idv; v.memrd = memrd; v.exwr = exwr;
    v.redir = redir; v.busy = busy; v.clr = clr; v.ctrl = ctrl; v.st = st;
    return v;
  endfunction

  function automatic logic [6:0] ctrl_now();
    return {hif.o_pcWrite, hif.o_ifidWrite, hif.o_ifidFlush, hif.o_idexWrite,
            hif.o_idexBubble, hif.o_exmemWrite, hif.o_exmemFlush};
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("ctrl",    64'(ctrl_now()),        64'(e.ctrl));
      check("state",   64'(hif.o_state),       64'(e.st));
      check("stall",   64'(hif.o_stallCnt),    64'(e.stall));
      check("flush",   64'(hif.o_flushCnt),    64'(e.flush));
      check("timeout", 64'(hif.o_memTimeout),  64'(e.tmo));
    end
  endtask

  // Drive one cycle at posedge+1, sample at negedge, then advance the model.
  task automatic apply(input vec_t v);
    exp_t       e;
    logic [6:0] mc;
    mc = 7'($urandom);
    mc[1] = v.memrd;
    hif.i_rdReg1 = v.rs1;     hif.i_rdReg2 = v.rs2;
    hif.i_idValid = v.idv;    hif.i_exCtrlMEM = mc;
    hif.i_exWriteReg = v.exwr;
    hif.i_redirect = v.redir; hif.i_dmemBusy = v.busy; hif.i_cntClr = v.clr;
    e.ctrl = v.ctrl; e.st = v.st; e.stall = m_stall; e.flush = m_flush; e.tmo = m_tmo;
    sb.push_back(e);
    @(negedge i_clk);
    compare_head();
    if (v.clr) begin
      m_stall = '0; m_flush = '0; m_run = 0; m_tmo = 1'b0;
    end else begin
      if (!v.ctrl[6] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (v.ctrl[4] && m_flush != '1)  m_flush = m_flush + 1'b1;
      if (v.busy) begin
        if (m_run < TMO) m_run++;
        if (m_run >= TMO) m_tmo = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  vec_t idle;
  vec_t busy_v;

  initial begin
    m_stall = '0; m_flush = '0; m_run = 0; m_tmo = 1'b0;
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0);
    tbl[0]  = idle;
    tbl[1]  = mk(5, 9, 1, 1, 5, 0, 0, 0, C_LU,    2'd0);
    tbl[2]  = mk(5, 9, 1, 1, 5, 0, 0, 0, C_RUN,   2'd1);
    tbl[3]  = idle;
    tbl[4]  = mk(0, 0, 1, 1, 0, 0, 0, 0, C_RUN,   2'd0);
    tbl[5]  = mk(3, 7, 0, 1, 7, 0, 0, 0, C_RUN,   2'd0);
    tbl[6]  = mk(3, 7, 1, 0, 7, 0, 0, 0, C_RUN,   2'd0);
    tbl[7]  = mk(3, 7, 1, 1, 7, 0, 0, 0, C_LU,    2'd0);
    tbl[8]  = mk(3, 7, 1, 1, 7, 1, 0, 0, C_REDIR, 2'd1);
    tbl[9]  = mk(3, 7, 1, 1, 7, 1, 0, 0, C_REDIR, 2'd0);
    tbl[10] = idle;
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, C_BUSY,  2'd0);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 0, C_BUSY,  2'd2);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 0, C_BUSY,  2'd2);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, C_REDIR, 2'd2);
    tbl[15] = idle;
    tbl[16] = mk(12, 4, 1, 1, 4, 0, 1, 0, C_BUSY, 2'd0);
    tbl[17] = mk(12, 4, 1, 1, 4, 0, 0, 0, C_LU,   2'd2);
    tbl[18] = mk(12, 4, 1, 1, 4, 0, 1, 0, C_BUSY, 2'd1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'd2);
    tbl[20] = mk(12, 4, 1, 1, 4, 0, 0, 1, C_LU,   2'd0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'd1);
    tbl[22] = mk(1, 2, 1, 1, 3, 0, 0, 0, C_RUN,   2'd0);

    hif.i_rdReg1 = '0; hif.i_rdReg2 = '0; hif.i_idValid = 1'b0;
    hif.i_exCtrlMEM = '0; hif.i_exWriteReg = '0; hif.i_redirect = 1'b0;
    hif.i_dmemBusy = 1'b0; hif.i_cntClr = 1'b0;

    // Reset state
    #1;
    check("rst_ctrl",  64'(ctrl_now()),       64'(C_RUN));
    check("rst_state", 64'(hif.o_state),      64'd0);
    check("rst_stall", 64'(hif.o_stallCnt),   64'd0);
    check("rst_flush", 64'(hif.o_flushCnt),   64'd0);
    check("rst_tmo",   64'(hif.o_memTimeout), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);

    // Busy for TMO+1 cycles: flag sets after the TMO-th busy cycle and is sticky.
    busy_v = mk(0, 0, 0, 0, 0, 0, 1, 0, C_BUSY, 2'd0);
    for (int i = 0; i < TMO + 1; i++) begin
      busy_v.st = (i == 0) ? 2'd0 : 2'd2;
      apply(busy_v);
      if (i == TMO - 2) check("tmo_not_yet", 64'(hif.o_memTimeout), 64'd0);
      if (i == TMO - 1) check("tmo_set",     64'(hif.o_memTimeout), 64'd1);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd2));
    check("tmo_sticky", 64'(hif.o_memTimeout), 64'd1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 2'd0));
    check("tmo_clr",     64'(hif.o_memTimeout), 64'd0);
    check("stall_clr",   64'(hif.o_stallCnt),   64'd0);
    apply(idle);

    // Long freeze drives the stall counter into saturation.
    for (int i = 0; i < 260; i++) begin
      busy_v.st = (i == 0) ? 2'd0 : 2'd2;
      apply(busy_v);
    end
    check("stall_sat", 64'(hif.o_stallCnt), 64'hFF);

    // Async reset while in MEMWAIT with a redirect pending.
    busy_v = mk(0, 0, 0, 0, 0, 1, 1, 0, C_BUSY, 2'd2);
    apply(busy_v);
    check("pre_rst_state", 64'(hif.o_state), 64'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_state", 64'(hif.o_state),      64'd0);
    check("arst_stall", 64'(hif.o_stallCnt),   64'd0);
    check("arst_flush", 64'(hif.o_flushCnt),   64'd0);
    check("arst_tmo",   64'(hif.o_memTimeout), 64'd0);
    check("arst_ctrl",  64'(ctrl_now()),       64'(C_BUSY));
    hif.i_redirect = 1'b0; hif.i_dmemBusy = 1'b0;
    #1;
    check("arst_idle_ctrl", 64'(ctrl_now()), 64'(C_RUN));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_stall = '0; m_flush = '0; m_run = 0; m_tmo = 1'b0;
    @(posedge i_clk);
    #1;
    apply(idle);
    apply(mk(5, 5, 1, 1, 5, 0, 0, 0, C_LU, 2'd0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd1));

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard controller for the 5-stage core, sitting beside ID decode and driving the write-enable/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards from decoded register reads and the EX-stage control bundle, applies taken-branch/jump redirects resolved in MEM, and freezes the pipeline while data memory is busy. It also keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- CNT_W, 32, width of performance counters
- MEM_TIMEOUT, 256, consecutive busy cycles before o_memTimeout sets

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rdReg1  input  5  ID-stage source register 1 from decode
- i_rdReg2  input  5  ID-stage source register 2 from decode
- i_idValid  input  1  IF/ID holds a valid instruction
- i_exCtrlMEM  input  7  EX-stage mem_ctrl_t; bit 1 = memRead
- i_exWriteReg  input  5  EX-stage destination register
- i_redirect  input  1  MEM-stage taken branch or jump
- i_dmemBusy  input  1  data memory cannot complete this cycle
- i_cntClr  input  1  synchronous clear of counters and timeout flag
- o_pcWrite  output  1  PC update enable
- o_ifidWrite  output  1  IF/ID load enable
- o_ifidFlush  output  1  IF/ID invalidate
- o_idexWrite  output  1  ID/EX load enable
- o_idexBubble  output  1  load NOP control into ID/EX
- o_exmemWrite  output  1  EX/MEM load enable
- o_exmemFlush  output  1  EX/MEM invalidate
- o_state  output  2  current FSM state (debug)
- o_stallCnt  output  CNT_W  cycles with PC held
- o_flushCnt  output  CNT_W  redirect events
- o_memTimeout  output  1  sticky timeout flag

## Operation
- Load-use hazard (LU) = i_idValid & i_exCtrlMEM[1] & i_exWriteReg != 0 & (i_exWriteReg == i_rdReg1 | i_exWriteReg == i_rdReg2).
- FSM states: RUN=0, LDSTALL=1, MEMWAIT=2.
- Priority each cycle: i_dmemBusy > i_redirect > LU.
- Busy (any state): all write enables 0, no flush/bubble; next state MEMWAIT. Redirect asserted during busy is held by the frozen EX/MEM and handled on the first non-busy cycle.
- MEMWAIT with busy low: evaluate exactly as RUN this cycle (same outputs and transitions).
- Redirect (not busy): o_pcWrite=1, all writes 1, o_ifidFlush=o_idexBubble=o_exmemFlush=1; o_flushCnt+1; next RUN.
- LU (not busy, no redirect): o_pcWrite=0, o_ifidWrite=0, o_idexBubble=1, o_idexWrite=1, o_exmemWrite=1; next LDSTALL.
- LDSTALL: LU detection masked (load now in MEM, forwarded); normal advance; next RUN unless busy/redirect.
- Otherwise: all writes 1, no flush/bubble.
- o_stallCnt increments every cycle o_pcWrite=0; counters saturate at all-ones.
- Busy-run counter counts consecutive busy cycles, clears when busy low; reaching MEM_TIMEOUT sets o_memTimeout until i_cntClr or reset. No effect on pipeline.
- i_cntClr clears counters/flag; same-cycle increment is discarded.

## Timing
- Control outputs combinational from state and inputs, zero latency; state, counters, flag registered on i_clk rising edge.
- Reset: state RUN, counters 0, o_memTimeout 0; outputs then reflect RUN with inputs (idle inputs: all writes 1, flushes 0, o_state 0).
- Reset mid-stall or mid-MEMWAIT returns to RUN immediately; no pending redirect retained.
- Redirect and LU same cycle: redirect only, no stall counted.
- rd == x0 in EX never causes LU.

## Structure
- Shared package: hazard_state_t enum; MEM_RD_BIT=1 constant alongside existing mem_ctrl_t/wb_ctrl_t.
- One natural sub-module: hz_sat_counter (parameterised width, inc/clr, saturating), instantiated twice.

## Test plan
- EX load x5, ID reads rs1=x5, valid -> one cycle o_pcWrite=0, o_idexBubble=1, state LDSTALL, o_stallCnt=1, then RUN.
- EX load x0, ID reads x0 -> no stall, o_stallCnt stays 0.
- i_redirect=1 together with LU -> all three flushes 1, o_pcWrite=1, o_flushCnt=1, o_stallCnt=0.
- i_dmemBusy for 3 cycles with redirect held -> all writes 0 for 3 cycles, state MEMWAIT, flush on 4th cycle, o_stallCnt=3.
- MEM_TIMEOUT=4, busy 5 cycles -> o_memTimeout sets after 4th busy cycle, stays after busy drops, clears on i_cntClr.
- Reset asserted during MEMWAIT -> state 0, counters 0 asynchronously.
